// File: rtl/uart_rx_core.sv
// uart_rx_core: asynchronous serial receiver, 8N1, LSB first.
// The line is double-flop synchronised. The start bit is qualified at mid-bit.
// Data and stop bits are sampled at their centres.
// Each received byte is presented with a one-cycle rx_valid strobe.
// A held/pending flag, an overrun flag and a framing-error strobe are also provided.
// Optional build macro UART_RX_PARITY_EN adds one parity bit between the data and
// stop bits, the PARITY_ODD parameter and the parity_err strobe output.
//
// Handshake: rx_valid is a one-cycle strobe with no backpressure. rx_data is valid
// while it is high and holds the last good byte afterwards. rx_pending stays high
// until the consumer pulses rx_ack. A completion in the same cycle as rx_ack keeps
// rx_pending set. overrun marks a completion that landed while rx_pending was
// still set and unacknowledged.
module uart_rx_core #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_pending,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t           state;
  logic [1:0]       sync;
  logic             rxs;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
`ifdef UART_RX_PARITY_EN
  logic             par_bit;
`endif

  // Two-flop synchroniser. It resets to 1 so the line reads as idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], uart_i};
    end
  end

  assign rxs     = sync[1];
  assign rx_busy = (state != IDLE);

  // Receive FSM. The bit timing and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_pending <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // The acknowledge clears the flags. A completion later in this block wins.
      if (rx_ack) begin
        rx_pending <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            clk_cnt <= '0;
            state   <= START;
          end
        end

        START: begin
          // Re-check the start bit at mid-bit. A high line here is a glitch.
          if (clk_cnt == CNT_HALF) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              clk_cnt <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt            <= '0;
            shift_reg[bit_idx] <= rxs;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= AFTER_DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            state   <= WAIT_IDLE;
            if (rxs) begin
              rx_data    <= shift_reg;
              rx_valid   <= 1'b1;
              rx_pending <= 1'b1;
              if (rx_pending && !rx_ack) begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err <= (^shift_reg) ^ par_bit ^ PARITY_ODD;
`endif
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          // Hold off a new start until the line has gone back high, so a break gives one error.
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
